// File: rtl/fas_pkg.sv
// Shared FAS FFT types: one complex point {re,im} and its |re|+|im| magnitude.
// Magnitude carries one extra bit so |-32768|+|-32768| is representable.
package fas_pkg;
  localparam int FFT_NPT  = 16;
  localparam int FFT_DW   = 16;
  localparam int FFT_IDXW = 4;

  typedef struct packed {
    logic [FFT_DW-1:0] re;
    logic [FFT_DW-1:0] im;
  } fft_pt_t;

  typedef logic [FFT_DW:0] fft_mag_t;
endpackage

// File: rtl/fft_abs_mag.sv
// Combinational |re|+|im| of a two's-complement point; zero latency, no flow control.
// Halves are sign-extended before negation so the negative limit maps to 2^(DW-1).
module fft_abs_mag
  import fas_pkg::*;
(
  input  fft_pt_t  pt,
  output fft_mag_t mag
);
  fft_mag_t re_x, im_x, re_abs, im_abs;

  assign re_x   = {pt.re[FFT_DW-1], pt.re};
  assign im_x   = {pt.im[FFT_DW-1], pt.im};
  assign re_abs = re_x[FFT_DW] ? fft_mag_t'(-re_x) : re_x;
  assign im_abs = im_x[FFT_DW] ? fft_mag_t'(-im_x) : im_x;
  assign mag    = re_abs + im_abs;
endmodule

// File: rtl/fft_frame_serializer.sv
// Captures 16-point FFT frames into ping-pong buffers and streams them one point per beat, first beat 1 cycle after capture.
// Back-pressure holds the current beat; a frame arriving with both buffers full is dropped and counted.
module fft_frame_serializer
  import fas_pkg::*;
#(
  parameter int DW  = FFT_DW,
  parameter int NPT = FFT_NPT,
  parameter int DCW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fft_valid,
  input  logic [2*DW-1:0]     fft_d0,
  input  logic [2*DW-1:0]     fft_d1,
  input  logic [2*DW-1:0]     fft_d2,
  input  logic [2*DW-1:0]     fft_d3,
  input  logic [2*DW-1:0]     fft_d4,
  input  logic [2*DW-1:0]     fft_d5,
  input  logic [2*DW-1:0]     fft_d6,
  input  logic [2*DW-1:0]     fft_d7,
  input  logic [2*DW-1:0]     fft_d8,
  input  logic [2*DW-1:0]     fft_d9,
  input  logic [2*DW-1:0]     fft_d10,
  input  logic [2*DW-1:0]     fft_d11,
  input  logic [2*DW-1:0]     fft_d12,
  input  logic [2*DW-1:0]     fft_d13,
  input  logic [2*DW-1:0]     fft_d14,
  input  logic [2*DW-1:0]     fft_d15,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DW-1:0]     out_data,
  output logic [FFT_IDXW-1:0] out_idx,
  output logic                out_last,
  output logic                frame_drop,
  output logic [DCW-1:0]      drop_cnt,
  output logic [FFT_IDXW-1:0] peak_idx,
  output logic                peak_valid
);
  localparam logic [FFT_IDXW-1:0] LAST = FFT_IDXW'(NPT-1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t              state;
  fft_pt_t             buf_mem [2][NPT];
  fft_pt_t             in_pts [NPT];
  fft_pt_t             cur_pt;
  fft_mag_t            cur_mag, acc_mag;
  logic [FFT_IDXW-1:0] beat_cnt, acc_idx;
  logic [1:0]          full, full_nxt;
  logic                rd_buf, wr_sel, cap, hs, last_hs;

  assign in_pts[0]  = fft_d0;
  assign in_pts[1]  = fft_d1;
  assign in_pts[2]  = fft_d2;
  assign in_pts[3]  = fft_d3;
  assign in_pts[4]  = fft_d4;
  assign in_pts[5]  = fft_d5;
  assign in_pts[6]  = fft_d6;
  assign in_pts[7]  = fft_d7;
  assign in_pts[8]  = fft_d8;
  assign in_pts[9]  = fft_d9;
  assign in_pts[10] = fft_d10;
  assign in_pts[11] = fft_d11;
  assign in_pts[12] = fft_d12;
  assign in_pts[13] = fft_d13;
  assign in_pts[14] = fft_d14;
  assign in_pts[15] = fft_d15;

  // Occupancy is sampled before the edge, so a buffer drained this cycle is not rewritten.
  assign wr_sel  = full[0];
  assign cap     = fft_valid && !(&full);
  assign hs      = out_valid && out_ready;
  assign last_hs = hs && (beat_cnt == LAST);
  assign cur_pt  = buf_mem[rd_buf][beat_cnt];

  fft_abs_mag u_abs_mag (
    .pt  (cur_pt),
    .mag (cur_mag)
  );

  always_comb begin
    full_nxt = full;
    if (last_hs) full_nxt[rd_buf] = 1'b0;
    if (cap)     full_nxt[wr_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      for (int k = 0; k < NPT; k++) buf_mem[wr_sel][k] <= in_pts[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      full       <= '0;
      rd_buf     <= 1'b0;
      beat_cnt   <= '0;
      out_valid  <= 1'b0;
      acc_mag    <= '0;
      acc_idx    <= '0;
      peak_idx   <= '0;
      peak_valid <= 1'b0;
      frame_drop <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      full       <= full_nxt;
      peak_valid <= 1'b0;
      frame_drop <= fft_valid && (&full);
      if (fft_valid && (&full) && !(&drop_cnt)) drop_cnt <= drop_cnt + DCW'(1);

      // Running peak: beat 0 seeds the accumulator, strict > keeps the lowest tied bin.
      if (hs && (beat_cnt == '0 || cur_mag > acc_mag)) begin
        acc_mag <= cur_mag;
        acc_idx <= beat_cnt;
      end
      if (last_hs) begin
        peak_idx   <= (cur_mag > acc_mag) ? beat_cnt : acc_idx;
        peak_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cap) begin
            state     <= STREAM;
            out_valid <= 1'b1;
            rd_buf    <= wr_sel;
            beat_cnt  <= '0;
          end
        end
        STREAM: begin
          if (hs) begin
            if (beat_cnt == LAST) begin
              beat_cnt <= '0;
              rd_buf   <= ~rd_buf;
              if (!full_nxt[~rd_buf]) begin
                state     <= IDLE;
                out_valid <= 1'b0;
              end
            end else begin
              beat_cnt <= beat_cnt + FFT_IDXW'(1);
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = out_valid ? cur_pt : '0;
  assign out_idx  = beat_cnt;
  assign out_last = out_valid && (beat_cnt == LAST);
endmodule

// File: tb/tb_fft_frame_serializer.sv
// Scoreboard bench: a frame-level model predicts beats, drops, peaks and out_valid;
// a separate monitor compares whatever the DUT presents against those predictions.
module tb_fft_frame_serializer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fft_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] frame [16];
  logic        out_valid, out_last, frame_drop, peak_valid;
  logic [31:0] out_data;
  logic [3:0]  out_idx, peak_idx;
  logic [7:0]  drop_cnt;
  logic        done = 1'b0;
  logic        timeout_err = 1'b0;

  always #5 clk = ~clk;

  fft_frame_serializer #(.DW(16), .NPT(16), .DCW(8)) dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(frame[0]),   .fft_d1(frame[1]),   .fft_d2(frame[2]),   .fft_d3(frame[3]),
    .fft_d4(frame[4]),   .fft_d5(frame[5]),   .fft_d6(frame[6]),   .fft_d7(frame[7]),
    .fft_d8(frame[8]),   .fft_d9(frame[9]),   .fft_d10(frame[10]), .fft_d11(frame[11]),
    .fft_d12(frame[12]), .fft_d13(frame[13]), .fft_d14(frame[14]), .fft_d15(frame[15]),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .frame_drop(frame_drop), .drop_cnt(drop_cnt),
    .peak_idx(peak_idx), .peak_valid(peak_valid)
  );

  typedef struct packed { logic [31:0] d; logic [3:0] idx; logic last; } beat_t;
  typedef struct packed { logic [63:0] due; logic [7:0] cnt; } drop_t;
  typedef struct packed { logic [63:0] due; logic [3:0] idx; } peak_t;
  typedef struct packed { logic [63:0] due; logic v; } vld_t;

  beat_t      beat_q [$];
  drop_t      drop_q [$];
  peak_t      peak_q [$];
  vld_t       vld_q  [$];
  logic [3:0] pend_q [$];
  int         stored, pos, m_drops;
  int         n_chk = 0, n_fail = 0;

  function automatic int absv(input logic [15:0] h);
    int v;
    v = int'($signed(h));
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [3:0] ref_peak();
    int best;
    logic [3:0] bi;
    best = -1;
    bi = 4'd0;
    for (int k = 0; k < 16; k++) begin
      int m;
      m = absv(frame[k][31:16]) + absv(frame[k][15:0]);
      if (m > best) begin
        best = m;
        bi = 4'(k);
      end
    end
    return bi;
  endfunction

  // Reference model: a depth-2 frame FIFO with occupancy sampled before each edge.
  logic [63:0] mdl_now;
  always @(negedge clk) begin : model
    mdl_now = $time;
    if (rst) begin
      beat_q.delete(); drop_q.delete(); peak_q.delete(); vld_q.delete(); pend_q.delete();
      stored = 0; pos = 0; m_drops = 0;
    end else begin
      if (fft_valid) begin
        if (stored == 2) begin
          if (m_drops < 255) m_drops++;
          drop_q.push_back('{mdl_now + 10, 8'(m_drops)});
        end else begin
          for (int k = 0; k < 16; k++) beat_q.push_back('{frame[k], 4'(k), k == 15});
          pend_q.push_back(ref_peak());
          stored++;
        end
      end
      if (out_valid && out_ready) begin
        if (pos == 15) begin
          pos = 0;
          if (stored > 0) stored--;
          if (pend_q.size() != 0) peak_q.push_back('{mdl_now + 10, pend_q.pop_front()});
        end else begin
          pos++;
        end
      end
      vld_q.push_back('{mdl_now + 10, stored > 0});
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  logic [63:0] mon_now;
  logic        m_prev_rst = 1'b1, m_prev_v = 1'b0, m_prev_r = 1'b0;
  beat_t       eb;
  drop_t       ed;
  peak_t       ep;
  always @(negedge clk) begin : monitor
    mon_now = $time;
    if (rst) begin
      m_prev_rst = 1'b1;
      m_prev_v = 1'b0;
    end else begin
      if (m_prev_rst) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_frame_drop", frame_drop, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_peak_idx", peak_idx, 0);
        chk("rst_peak_valid", peak_valid, 0);
        m_prev_rst = 1'b0;
      end
      if (m_prev_v && !m_prev_r) chk("stall_valid_held", out_valid, 1);
      if (out_valid) begin
        chk("beat_expected", beat_q.size() != 0, 1);
        if (beat_q.size() != 0) begin
          eb = beat_q[0];
          chk("out_data", out_data, eb.d);
          chk("out_idx", out_idx, eb.idx);
          chk("out_last", out_last, eb.last);
          if (out_ready) void'(beat_q.pop_front());
        end
      end
      while (vld_q.size() != 0 && vld_q[0].due < mon_now) void'(vld_q.pop_front());
      if (vld_q.size() != 0 && vld_q[0].due == mon_now) begin
        chk("out_valid", out_valid, vld_q[0].v);
        void'(vld_q.pop_front());
      end
      if (frame_drop) begin
        chk("drop_expected", drop_q.size() != 0, 1);
        if (drop_q.size() != 0) begin
          ed = drop_q.pop_front();
          chk("drop_time", mon_now, ed.due);
          chk("drop_cnt", drop_cnt, ed.cnt);
        end
      end
      while (drop_q.size() != 0 && drop_q[0].due <= mon_now) begin
        chk("drop_pulse", frame_drop, 1);
        void'(drop_q.pop_front());
      end
      if (peak_valid) begin
        chk("peak_expected", peak_q.size() != 0, 1);
        if (peak_q.size() != 0) begin
          ep = peak_q.pop_front();
          chk("peak_time", mon_now, ep.due);
          chk("peak_idx", peak_idx, ep.idx);
        end
      end
      while (peak_q.size() != 0 && peak_q[0].due <= mon_now) begin
        chk("peak_pulse", peak_valid, 1);
        void'(peak_q.pop_front());
      end
      m_prev_v = out_valid;
      m_prev_r = out_ready;
    end
    if (done) begin
      chk("no_timeout", timeout_err, 0);
      chk("beats_left", beat_q.size(), 0);
      chk("peaks_left", peak_q.size(), 0);
      chk("final_drop_cnt", drop_cnt, 8'(m_drops));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send();
    fft_valid = 1'b1;
    tick();
    fft_valid = 1'b0;
  endtask

  task automatic zero_frame();
    for (int k = 0; k < 16; k++) frame[k] = 32'h0;
  endtask

  task automatic ramp_frame();
    for (int k = 0; k < 16; k++) frame[k] = {16'(k * 256), 16'(-k)};
  endtask

  task automatic rand_frame();
    for (int k = 0; k < 16; k++) begin
      logic [15:0] r, i;
      r = 16'($urandom);
      i = 16'($urandom);
      case ($urandom_range(7))
        0: r = 16'h8000;
        1: i = 16'h8000;
        2: r = 16'h7FFF;
        default: ;
      endcase
      frame[k] = {r, i};
    end
  endtask

  initial begin : driver
    logic found;
    zero_frame();
    repeat (3) tick();
    rst = 1'b0;

    // Ramp frame, always ready
    ramp_frame();
    out_ready = 1'b1;
    send();
    repeat (20) tick();

    // Ready pattern 1,0,0,1
    ramp_frame();
    for (int i = 0; i < 80; i++) begin
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      fft_valid = (i == 0);
      tick();
    end
    fft_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();

    // Three frames while stalled: third is dropped
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      rand_frame();
      send();
      tick();
    end
    repeat (3) tick();
    out_ready = 1'b1;
    repeat (40) tick();

    // Peak tie keeps lower bin
    zero_frame();
    frame[1] = 32'h0200_0000;
    frame[15] = 32'h0000_FE00;
    send();
    repeat (20) tick();

    // Negative limit magnitude
    zero_frame();
    frame[3] = 32'h7FFF_7FFF;
    frame[7] = 32'h8000_8000;
    send();
    repeat (20) tick();

    // Drop counter saturation
    out_ready = 1'b0;
    rand_frame();
    send();
    rand_frame();
    send();
    fft_valid = 1'b1;
    repeat (260) tick();
    fft_valid = 1'b0;
    out_ready = 1'b1;
    repeat (40) tick();

    // Reset in the middle of a frame
    ramp_frame();
    send();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (out_valid && out_idx == 4'd8) found = 1'b1;
      else tick();
    end
    if (!found) timeout_err = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    rand_frame();
    send();
    repeat (20) tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(11) == 0) begin
        rand_frame();
        fft_valid = 1'b1;
      end
      tick();
      fft_valid = 1'b0;
    end

    out_ready = 1'b1;
    repeat (60) tick();
    done = 1'b1;
    repeat (5) tick();
  end
endmodule
